// File: rtl/mul_step_seq.sv
`default_nettype none
// ============================================================================
// Module   : mul_step_seq
// Purpose  : Iterative unsigned N x N mantissa multiplier. One shift-add row
//            is reused for N cycles, one multiplier bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mul_step_seq #(
   parameter int N = 24
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic           abort,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] p,
   output logic           busy
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] c_last = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        r_state;
   logic [N-1:0]  r_a;
   logic [N-1:0]  r_b;
   logic [N-2:0]  r_s;
   logic          r_c;
   logic [N-1:0]  r_l;
   logic [CW-1:0] r_cnt;
   logic          r_in_ready;
   logic          r_out_valid;
   logic          r_busy;
   logic [N:0]    w_row;

   // {C,S} is the upper N bits of the running product; add the gated
   // multiplicand, then everything shifts right by one bit.
   assign w_row = {1'b0, r_c, r_s} + {1'b0, r_a & {N{r_b[0]}}};

   assign p         = {r_c, r_s, r_l};
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_s         <= '0;
         r_c         <= 1'b0;
         r_l         <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // abort has no effect here; a simultaneous request is accepted
               if (in_valid) begin
                  r_a        <= a;
                  r_b        <= b;
                  r_s        <= '0;
                  r_c        <= 1'b0;
                  r_l        <= '0;
                  r_cnt      <= '0;
                  r_state    <= S_RUN;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            S_RUN: begin
               if (abort) begin
                  r_state    <= S_IDLE;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b0;
               end else begin
                  r_s   <= w_row[N-1:1];
                  r_c   <= w_row[N];
                  r_l   <= {w_row[0], r_l[N-1:1]};
                  r_b   <= r_b >> 1;
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == c_last) begin
                     r_state     <= S_DONE;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (abort || out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
